mar_seq: RTL

- Parametrised memory address register for the 8-bit CPU datapath.
- Loads an address from the internal data bus and drives the memory address bus.
- Adds post-increment, decrement, a one-deep save/restore shadow, and wrap or saturate boundary handling.
- Serves sequential memory walks: block copies, stack-style access, and operand fetch runs.

---
 rtl/mar_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mar_seq.sv
// Memory address register: load, post-increment/decrement, one-deep save/restore shadow, wrap or saturate.
// Define MAR_PAGE_EN to add a page register (PAGE, IPAGEn) that extends the address above ABUS.

module mar_seq #(
   parameter int                ADDR_W    = 8,
   parameter int                WRAP_MODE = 1,
   parameter logic [ADDR_W-1:0] RST_ADDR  = '0
`ifdef MAR_PAGE_EN
   ,
   parameter int                PAGE_W    = 4
`endif
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IMARn,
   input  logic              INCn,
   input  logic              DECn,
   input  logic              SAVEn,
   input  logic              RESTn,
   input  logic [ADDR_W-1:0] D,
`ifdef MAR_PAGE_EN
   input  logic              IPAGEn,
   output logic [PAGE_W-1:0] PAGE,
`endif
   output logic [ADDR_W-1:0] ABUS,
   output logic              WRAP,
   output logic              SHV
);

   // The stepped quantity is {page, offset} when paging is built in, else just the offset,
   // so carries and borrows between the two fall out of plain binary arithmetic.
`ifdef MAR_PAGE_EN
   localparam int CW = PAGE_W + ADDR_W;
`else
   localparam int CW = ADDR_W;
`endif

   localparam logic [CW-1:0] RST_CUR = CW'(RST_ADDR);
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [CW-1:0] MAX     = '1;
   localparam logic [CW-1:0] ZERO    = '0;

   logic [CW-1:0] cur_q;
   logic [CW-1:0] cur_d;
   logic [CW-1:0] shadow_q;
   logic [CW-1:0] shadow_d;
   logic          wrap_q;
   logic          wrap_d;
   logic          shv_q;
   logic          shv_d;
   logic          load;
   logic          inc_only;
   logic          dec_only;
   logic          rest_ok;

   always_comb begin
`ifdef MAR_PAGE_EN
      load = !IMARn || !IPAGEn;
`else
      load = !IMARn;
`endif
      inc_only = !INCn && DECn;
      dec_only = !DECn && INCn;
      rest_ok  = !RESTn && shv_q;
   end

   always_comb begin
      cur_d    = cur_q;
      shadow_d = shadow_q;
      shv_d    = shv_q;
      wrap_d   = 1'b0;

      if (load) begin
         if (!IMARn) cur_d[ADDR_W-1:0] = D;
`ifdef MAR_PAGE_EN
         if (!IPAGEn) cur_d[CW-1:ADDR_W] = D[PAGE_W-1:0];
`endif
      end else if (rest_ok) begin
         cur_d = shadow_q;
      end else if (inc_only) begin
         if (cur_q == MAX) begin
            wrap_d = 1'b1;
            cur_d  = (WRAP_MODE != 0) ? ZERO : MAX;
         end else begin
            cur_d = cur_q + ONE;
         end
      end else if (dec_only) begin
         if (cur_q == ZERO) begin
            wrap_d = 1'b1;
            cur_d  = (WRAP_MODE != 0) ? MAX : ZERO;
         end else begin
            cur_d = cur_q - ONE;
         end
      end

      // Save always captures the pre-edge address, so SAVEn with RESTn swaps the two.
      if (!SAVEn) begin
         shadow_d = cur_q;
         shv_d    = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cur_q    <= RST_CUR;
         shadow_q <= RST_CUR;
         wrap_q   <= 1'b0;
         shv_q    <= 1'b0;
      end else begin
         cur_q    <= cur_d;
         shadow_q <= shadow_d;
         wrap_q   <= wrap_d;
         shv_q    <= shv_d;
      end
   end

   assign ABUS = cur_q[ADDR_W-1:0];
   assign WRAP = wrap_q;
   assign SHV  = shv_q;
`ifdef MAR_PAGE_EN
   assign PAGE = cur_q[CW-1:ADDR_W];
`endif

endmodule
